// File: rtl/lcd_fb_capture.sv
// lcd_fb_capture: packs the PPU LCD pixel stream into a double-buffered 2bpp framebuffer.
// Ports:
//   clk_i          system clock shared with the PPU
//   rst_ni         synchronous active-low reset
//   lcd_pixel_i    pixel strobe, one clock per pixel
//   lcd_color_i    2-bit shade, valid with lcd_pixel_i
//   lcd_hsync_i    rising edge ends the current line
//   lcd_vsync_i    rising edge ends the current frame
//   err_clr_i      clears the sticky error flags
//   fb_we_o        framebuffer byte write strobe
//   fb_bank_o      bank of the byte being written (aligned with fb_we_o)
//   fb_addr_o      byte address within the bank
//   fb_wdata_o     four packed pixels, pixel k in bits [2k+1:2k]
//   disp_bank_o    bank holding the last complete frame
//   frame_done_o   one-clock pulse when a complete frame is committed
//   err_long_o     sticky: a pixel past the line end or a line past the frame end was dropped
//   err_short_o    sticky: a line or frame ended early
module lcd_fb_capture #(
  parameter int H_PIXELS = 160,
  parameter int V_LINES  = 144,
  parameter int FB_AW    = 13
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             lcd_pixel_i,
  input  logic [1:0]       lcd_color_i,
  input  logic             lcd_hsync_i,
  input  logic             lcd_vsync_i,
  input  logic             err_clr_i,
  output logic             fb_we_o,
  output logic             fb_bank_o,
  output logic [FB_AW-1:0] fb_addr_o,
  output logic [7:0]       fb_wdata_o,
  output logic             disp_bank_o,
  output logic             frame_done_o,
  output logic             err_long_o,
  output logic             err_short_o
);
  localparam int XW = $clog2(H_PIXELS + 1);
  localparam int YW = $clog2(V_LINES + 1);
  localparam logic [XW-1:0] X_MAX = XW'(H_PIXELS);
  localparam logic [YW-1:0] Y_MAX = YW'(V_LINES);
  localparam logic [FB_AW-1:0] LINE_B = FB_AW'(H_PIXELS / 4);
  typedef enum logic {SYNC, ACTIVE} state_t;
  state_t state_q, state_d;
  logic [XW-1:0] x_q, x_d, x1;
  logic [YW-1:0] y_q, y_d, y_end;
  logic [FB_AW-1:0] addr_q, addr_d, base_q, base_d, waddr_q;
  logic [7:0] pack_q, pack_d, wdata_q;
  logic bank_q, bank_d, wbank_q, disp_q, disp_d, we_q, we_d, done_q;
  logic el_q, el_d, es_q, es_d, hs_q, vs_q;
  logic act, hs_edge, vs_edge, pix_ok, pix_drop, grp_full, line_end, flip;
  always_comb begin
    act = state_q == ACTIVE;
    hs_edge = lcd_hsync_i & ~hs_q;
    vs_edge = lcd_vsync_i & ~vs_q;
    pix_ok = act && lcd_pixel_i && x_q < X_MAX && y_q < Y_MAX;
    pix_drop = act && lcd_pixel_i && !pix_ok;
    x1 = x_q + XW'(pix_ok);
    // slot 0 of a new group starts from a clean byte so a partial flush has zeroed unused slots
    pack_d = pix_ok ? ((x_q[1:0] == 2'd0 ? 8'h00 : pack_q) | (8'(lcd_color_i) << {x_q[1:0], 1'b0})) : pack_q;
    grp_full = pix_ok && x_q[1:0] == 2'd3;
    // vsync closes a pending partial line exactly like hsync; blank lines are not counted
    line_end = act && (hs_edge || vs_edge) && x1 != '0;
    y_end = (line_end && y_q != Y_MAX) ? y_q + 1'b1 : y_q;
    flip = act && vs_edge && y_end == Y_MAX;
    state_d = (state_q == SYNC && vs_edge) ? ACTIVE : state_q;
    // a completed group always has x1%4==0, so it never coincides with a flush
    we_d = grp_full || (line_end && x1[1:0] != 2'd0);
    x_d = (line_end || vs_edge) ? '0 : x1;
    y_d = vs_edge ? '0 : y_end;
    base_d = vs_edge ? '0 : line_end ? base_q + LINE_B : base_q;
    addr_d = vs_edge ? '0 : line_end ? base_q + LINE_B : grp_full ? addr_q + 1'b1 : addr_q;
    bank_d = flip ? ~bank_q : bank_q;
    disp_d = flip ? bank_q : disp_q;
    el_d = pix_drop || (el_q && !err_clr_i);
    es_d = (line_end && x1 < X_MAX) || (act && vs_edge && !flip) || (es_q && !err_clr_i);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= SYNC;
      x_q <= '0;
      y_q <= '0;
      addr_q <= '0;
      base_q <= '0;
      pack_q <= '0;
      bank_q <= 1'b0;
      disp_q <= 1'b1;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      we_q <= 1'b0;
      wbank_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q <= 1'b0;
      el_q <= 1'b0;
      es_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      addr_q <= addr_d;
      base_q <= base_d;
      pack_q <= pack_d;
      bank_q <= bank_d;
      disp_q <= disp_d;
      hs_q <= lcd_hsync_i;
      vs_q <= lcd_vsync_i;
      we_q <= we_d;
      wbank_q <= bank_q;
      waddr_q <= addr_q;
      wdata_q <= pack_d;
      done_q <= flip;
      el_q <= el_d;
      es_q <= es_d;
    end
  end
  assign fb_we_o = we_q;
  assign fb_bank_o = wbank_q;
  assign fb_addr_o = waddr_q;
  assign fb_wdata_o = wdata_q;
  assign disp_bank_o = disp_q;
  assign frame_done_o = done_q;
  assign err_long_o = el_q;
  assign err_short_o = es_q;
endmodule
